// File: rtl/crc8_frame_checker.sv
// crc8_frame_checker
//   Receive-side CRC-8 checker for the LVDS link. Each frame is its payload
//   bytes followed by one CRC-8 trailer byte, marked with i_last. The CRC is
//   recomputed over every byte including the trailer, and pass/fail is reported
//   at the end of the frame. Payload bytes are forwarded downstream and the
//   CRC byte is stripped.
//
//   Parameters: POLY (generator, implicit x^8, MSB-first), INIT (start value,
//               no final XOR), MAX_LEN (payload limit, 1..255).
//   Ports:
//     i_clk, i_arst_n        : clock, async active-low reset
//     i_valid/i_data/i_last  : input byte stream (no backpressure)
//     o_valid/o_data/o_last  : forwarded payload stream
//     o_done                 : one-cycle pulse at frame end
//     o_crc_ok, o_len_err    : frame status, held until the next o_done
//     o_err_cnt              : saturating count of failed frames, present only
//                              when CRC8_CHECK_ERR_CNT_EN is defined
//
//   state   | meaning
//   IDLE    | no byte held, waiting for the first byte of a frame
//   HOLD    | one byte held; it may still turn out to be the last payload byte
//   DISCARD | payload overflowed MAX_LEN, swallowing bytes up to i_last
module crc8_frame_checker #(
  parameter logic [7:0] POLY    = 8'h07,
  parameter logic [7:0] INIT    = 8'h00,
  parameter int         MAX_LEN = 64
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  output logic        o_done,
  output logic        o_crc_ok,
  output logic        o_len_err
`ifdef CRC8_CHECK_ERR_CNT_EN
  ,
  output logic [15:0] o_err_cnt
`endif
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HOLD, DISCARD} state_t;

  state_t           state_q;
  logic [7:0]       hold_q;
  logic [7:0]       crc_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       crc_nx;
  logic [7:0]       crc_first;

  function automatic logic [7:0] crc_f(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    r = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ POLY) : (r << 1);
    end
    return r;
  endfunction

  assign crc_nx    = crc_f(crc_q, i_data);
  assign crc_first = crc_f(INIT, i_data);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= IDLE;
      hold_q    <= 8'h00;
      crc_q     <= INIT;
      len_q     <= '0;
      o_valid   <= 1'b0;
      o_data    <= 8'h00;
      o_last    <= 1'b0;
      o_done    <= 1'b0;
      o_crc_ok  <= 1'b0;
      o_len_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
      if (i_valid) begin
        case (state_q)
          IDLE: begin
            if (i_last) begin
              // trailer with no payload in front of it
              o_done    <= 1'b1;
              o_crc_ok  <= 1'b0;
              o_len_err <= 1'b1;
            end else begin
              hold_q  <= i_data;
              len_q   <= LEN_W'(1);
              crc_q   <= crc_first;
              state_q <= HOLD;
            end
          end
          HOLD: begin
            // a new byte proves the held one is payload, so it can go out
            o_valid <= 1'b1;
            o_data  <= hold_q;
            if (i_last) begin
              o_last    <= 1'b1;
              o_done    <= 1'b1;
              o_crc_ok  <= (crc_nx == 8'h00);
              o_len_err <= 1'b0;
              crc_q     <= INIT;
              len_q     <= '0;
              state_q   <= IDLE;
            end else if (len_q == LEN_MAX) begin
              o_last  <= 1'b1;
              crc_q   <= INIT;
              len_q   <= '0;
              state_q <= DISCARD;
            end else begin
              hold_q <= i_data;
              len_q  <= len_q + LEN_W'(1);
              crc_q  <= crc_nx;
            end
          end
          DISCARD: begin
            if (i_last) begin
              o_done    <= 1'b1;
              o_crc_ok  <= 1'b0;
              o_len_err <= 1'b1;
              state_q   <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef CRC8_CHECK_ERR_CNT_EN
  // Every frame end reports failure except a HOLD frame with a zero residue.
  logic fail_evt;
  assign fail_evt = i_valid & i_last & ((state_q != HOLD) | (crc_nx != 8'h00));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_err_cnt <= 16'h0000;
    end else if (fail_evt && (o_err_cnt != 16'hFFFF)) begin
      o_err_cnt <= o_err_cnt + 16'd1;
    end
  end
`endif

endmodule
